// File: rtl/decode_pipe.sv
// Instruction decode stage: register file with write-first bypass, immediate
// extension, load-use hazard detection and the ID/EX pipeline register.
module decode_pipe #(
   parameter int LEN         = 32,
   parameter int NREG        = 32,
   parameter int EX_W        = 9,
   parameter int MEM_W       = 3,
   parameter int WB_W        = 2,
   parameter int MEMREAD_BIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [LEN-1:0]   in_pc_branch,
   input  logic [31:0]      in_instruccion,
   input  logic [EX_W-1:0]  in_execute_bus,
   input  logic [MEM_W-1:0] in_memory_bus,
   input  logic [WB_W-1:0]  in_writeBack_bus,
   input  logic             in_zero_ext,
   input  logic             RegWrite,
   input  logic [4:0]       write_register,
   input  logic [LEN-1:0]   write_data,
   input  logic             flush,
   input  logic             hold,
   output logic             stall,
   output logic             out_valid,
   output logic [LEN-1:0]   out_pc_branch,
   output logic [LEN-1:0]   out_reg1,
   output logic [LEN-1:0]   out_reg2,
   output logic [LEN-1:0]   out_sign_extend,
   output logic [LEN-1:0]   out_pc_jump,
   output logic [4:0]       out_rs,
   output logic [4:0]       out_rt,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_shamt,
   output logic [EX_W-1:0]  execute_bus,
   output logic [MEM_W-1:0] memory_bus,
   output logic [WB_W-1:0]  writeBack_bus,
   output logic [15:0]      stall_count
);

   typedef enum logic [1:0] {
      ACT_LOAD,
      ACT_BUBBLE,
      ACT_HOLD,
      ACT_FLUSH
   } action_e;

   typedef struct packed {
      logic             valid;
      logic [LEN-1:0]   pc_branch;
      logic [LEN-1:0]   reg1;
      logic [LEN-1:0]   reg2;
      logic [LEN-1:0]   sext;
      logic [4:0]       rs;
      logic [4:0]       rt;
      logic [4:0]       rd;
      logic [4:0]       shamt;
      logic [EX_W-1:0]  ex;
      logic [MEM_W-1:0] mem;
      logic [WB_W-1:0]  wb;
   } idex_t;

   logic [LEN-1:0] regs_q [NREG];
   idex_t          idex_q, idex_d;
   logic [15:0]    stall_count_q, stall_count_d;

   logic [4:0]     dec_rs, dec_rt, dec_rd, dec_shamt;
   logic [LEN-1:0] dec_imm, rd1, rd2;
   logic           wr_en;
   action_e        action;
   logic           unused_opcode;

   assign dec_rs        = in_instruccion[25:21];
   assign dec_rt        = in_instruccion[20:16];
   assign dec_rd        = in_instruccion[15:11];
   assign dec_shamt     = in_instruccion[10:6];
   assign unused_opcode = ^in_instruccion[31:26];

   assign dec_imm = in_zero_ext ? {{(LEN-16){1'b0}}, in_instruccion[15:0]}
                                : {{(LEN-16){in_instruccion[15]}}, in_instruccion[15:0]};

   assign out_pc_jump = {in_pc_branch[LEN-1:28], in_instruccion[25:0], 2'b00};

   // Writes to r0 or to indices beyond the file are dropped entirely.
   assign wr_en = RegWrite && (write_register != 5'd0) && (int'(write_register) < NREG);

   // NOTE: register file is reset because a cleared file is part of the reset contract;
   // drop the reset branch for RAM inference only if that contract changes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         for (int i = 1; i < NREG; i++) begin
            if (write_register == 5'(i)) regs_q[i] <= write_data;
         end
      end
   end

   // Read ports: out-of-range and r0 return 0; a same-cycle write is bypassed.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int i = 1; i < NREG; i++) begin
         if (dec_rs == 5'(i)) rd1 = regs_q[i];
         if (dec_rt == 5'(i)) rd2 = regs_q[i];
      end
      if (wr_en && write_register == dec_rs) rd1 = write_data;
      if (wr_en && write_register == dec_rt) rd2 = write_data;
   end

   assign stall = in_valid && idex_q.valid && idex_q.mem[MEMREAD_BIT] &&
                  (idex_q.rt != 5'd0) &&
                  ((idex_q.rt == dec_rs) || (idex_q.rt == dec_rt));

   always_comb begin
      if (flush)      action = ACT_FLUSH;
      else if (hold)  action = ACT_HOLD;
      else if (stall) action = ACT_BUBBLE;
      else            action = ACT_LOAD;
   end

   // NOTE: every _d is defaulted to its _q first so no path through the case infers a latch.
   always_comb begin
      idex_d        = idex_q;
      stall_count_d = stall_count_q;
      unique case (action)
         ACT_FLUSH, ACT_BUBBLE: begin
            idex_d.valid = 1'b0;
            idex_d.ex    = '0;
            idex_d.mem   = '0;
            idex_d.wb    = '0;
            if (action == ACT_BUBBLE && stall_count_q != 16'hFFFF)
               stall_count_d = stall_count_q + 16'd1;
         end
         ACT_HOLD: ;
         ACT_LOAD: begin
            idex_d.valid     = in_valid;
            idex_d.pc_branch = in_pc_branch;
            idex_d.reg1      = rd1;
            idex_d.reg2      = rd2;
            idex_d.sext      = dec_imm;
            idex_d.rs        = dec_rs;
            idex_d.rt        = dec_rt;
            idex_d.rd        = dec_rd;
            idex_d.shamt     = dec_shamt;
            idex_d.ex        = in_valid ? in_execute_bus   : '0;
            idex_d.mem       = in_valid ? in_memory_bus    : '0;
            idex_d.wb        = in_valid ? in_writeBack_bus : '0;
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idex_q        <= '0;
         stall_count_q <= '0;
      end else begin
         idex_q        <= idex_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign out_valid       = idex_q.valid;
   assign out_pc_branch   = idex_q.pc_branch;
   assign out_reg1        = idex_q.reg1;
   assign out_reg2        = idex_q.reg2;
   assign out_sign_extend = idex_q.sext;
   assign out_rs          = idex_q.rs;
   assign out_rt          = idex_q.rt;
   assign out_rd          = idex_q.rd;
   assign out_shamt       = idex_q.shamt;
   assign execute_bus     = idex_q.ex;
   assign memory_bus      = idex_q.mem;
   assign writeBack_bus   = idex_q.wb;
   assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: register file, immediates, jump target,
// load-use bubbles, flush/hold priority, counter saturation and async reset.
module tb_decode_pipe;

   localparam int LEN = 32;

   localparam logic [31:0] I_LW  = 32'h8C23_0000;  // lw  r3, 0(r1)
   localparam logic [31:0] I_ADD = 32'h0062_2020;  // add r4, r3, r2

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic [LEN-1:0]  in_pc_branch;
   logic [31:0]     in_instruccion;
   logic [8:0]      in_execute_bus;
   logic [2:0]      in_memory_bus;
   logic [1:0]      in_writeBack_bus;
   logic            in_zero_ext;
   logic            RegWrite;
   logic [4:0]      write_register;
   logic [LEN-1:0]  write_data;
   logic            flush;
   logic            hold;
   logic            stall;
   logic            out_valid;
   logic [LEN-1:0]  out_pc_branch, out_reg1, out_reg2, out_sign_extend, out_pc_jump;
   logic [4:0]      out_rs, out_rt, out_rd, out_shamt;
   logic [8:0]      execute_bus;
   logic [2:0]      memory_bus;
   logic [1:0]      writeBack_bus;
   logic [15:0]     stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_pipe dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_pc_branch     (in_pc_branch),
      .in_instruccion   (in_instruccion),
      .in_execute_bus   (in_execute_bus),
      .in_memory_bus    (in_memory_bus),
      .in_writeBack_bus (in_writeBack_bus),
      .in_zero_ext      (in_zero_ext),
      .RegWrite         (RegWrite),
      .write_register   (write_register),
      .write_data       (write_data),
      .flush            (flush),
      .hold             (hold),
      .stall            (stall),
      .out_valid        (out_valid),
      .out_pc_branch    (out_pc_branch),
      .out_reg1         (out_reg1),
      .out_reg2         (out_reg2),
      .out_sign_extend  (out_sign_extend),
      .out_pc_jump      (out_pc_jump),
      .out_rs           (out_rs),
      .out_rt           (out_rt),
      .out_rd           (out_rd),
      .out_shamt        (out_shamt),
      .execute_bus      (execute_bus),
      .memory_bus       (memory_bus),
      .writeBack_bus    (writeBack_bus),
      .stall_count      (stall_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_lw();
      in_instruccion   = I_LW;
      in_execute_bus   = 9'h0A1;
      in_memory_bus    = 3'b010;
      in_writeBack_bus = 2'b11;
   endtask

   task automatic drive_add();
      in_instruccion   = I_ADD;
      in_execute_bus   = 9'h1C2;
      in_memory_bus    = 3'b000;
      in_writeBack_bus = 2'b10;
   endtask

   initial begin
      reset            = 1'b0;
      in_valid         = 1'b0;
      in_pc_branch     = '0;
      in_instruccion   = '0;
      in_execute_bus   = '0;
      in_memory_bus    = '0;
      in_writeBack_bus = '0;
      in_zero_ext      = 1'b0;
      RegWrite         = 1'b0;
      write_register   = '0;
      write_data       = '0;
      flush            = 1'b0;
      hold             = 1'b0;
      #2;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(stall_count), 64'd0);
      check("rst_reg1", 64'(out_reg1), 64'd0);
      check("rst_ex", 64'(execute_bus), 64'd0);
      reset = 1'b1;

      // Same-cycle write of r5 is bypassed to the read port.
      in_valid       = 1'b1;
      RegWrite       = 1'b1;
      write_register = 5'd5;
      write_data     = 32'h0000_1234;
      in_instruccion = 32'h00A0_0000;
      in_pc_branch   = 32'h0000_0104;
      tick();
      check("bypass_reg1", 64'(out_reg1), 64'h1234);
      check("bypass_valid", 64'(out_valid), 64'd1);
      check("bypass_rs", 64'(out_rs), 64'd5);
      check("bypass_pc", 64'(out_pc_branch), 64'h104);

      // Writing r0 is ignored, even through the bypass.
      write_register = 5'd0;
      write_data     = 32'hFFFF_FFFF;
      in_instruccion = 32'h0005_0000;
      tick();
      check("r0_bypass", 64'(out_reg1), 64'd0);
      check("r5_file", 64'(out_reg2), 64'h1234);
      RegWrite = 1'b0;
      tick();
      check("r0_file", 64'(out_reg1), 64'd0);

      in_instruccion = 32'h0000_8000;
      in_zero_ext    = 1'b0;
      tick();
      check("imm_sext", 64'(out_sign_extend), 64'hFFFF_8000);
      in_zero_ext = 1'b1;
      tick();
      check("imm_zext", 64'(out_sign_extend), 64'h0000_8000);
      in_zero_ext = 1'b0;

      in_pc_branch   = 32'hA000_0004;
      in_instruccion = 32'h0BFF_FFFF;
      #1;
      check("pc_jump", 64'(out_pc_jump), 64'hAFFF_FFFC);
      tick();
      check("rd_field", 64'(out_rd), 64'd31);
      check("shamt_field", 64'(out_shamt), 64'd31);
      check("pc_branch", 64'(out_pc_branch), 64'hA000_0004);

      // Load-use: hold first (no bubble counted), then exactly one bubble.
      drive_lw();
      tick();
      check("lw_valid", 64'(out_valid), 64'd1);
      check("lw_mem", 64'(memory_bus), 64'd2);
      check("lw_rt", 64'(out_rt), 64'd3);
      drive_add();
      hold = 1'b1;
      #1;
      check("lu_stall", 64'(stall), 64'd1);
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ex", 64'(execute_bus), 64'h0A1);
      check("hold_nocount", 64'(stall_count), 64'd0);
      hold = 1'b0;
      tick();
      check("bubble_valid", 64'(out_valid), 64'd0);
      check("bubble_ex", 64'(execute_bus), 64'd0);
      check("bubble_count", 64'(stall_count), 64'd1);
      check("bubble_stall_low", 64'(stall), 64'd0);
      tick();
      check("add_valid", 64'(out_valid), 64'd1);
      check("add_ex", 64'(execute_bus), 64'h1C2);
      check("add_rs", 64'(out_rs), 64'd3);
      check("add_rt", 64'(out_rt), 64'd2);
      check("add_rd", 64'(out_rd), 64'd4);
      check("add_count", 64'(stall_count), 64'd1);

      // Flush beats a pending hazard and is not counted.
      drive_lw();
      tick();
      drive_add();
      flush = 1'b1;
      #1;
      check("flush_stall_out", 64'(stall), 64'd1);
      tick();
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_mem", 64'(memory_bus), 64'd0);
      check("flush_count", 64'(stall_count), 64'd1);
      flush = 1'b0;

      tick();
      check("reload_valid", 64'(out_valid), 64'd1);
      check("reload_ex", 64'(execute_bus), 64'h1C2);
      flush = 1'b1;
      hold  = 1'b1;
      tick();
      check("fh_valid", 64'(out_valid), 64'd0);
      check("fh_ex", 64'(execute_bus), 64'd0);
      flush          = 1'b0;
      in_instruccion = 32'hFFFF_FFFF;
      in_pc_branch   = 32'h1234_5678;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("frz_valid", 64'(out_valid), 64'd0);
         check("frz_rs", 64'(out_rs), 64'd3);
         check("frz_pc", 64'(out_pc_branch), 64'hA000_0004);
         check("frz_wb", 64'(writeBack_bus), 64'd0);
         check("frz_count", 64'(stall_count), 64'd1);
      end
      hold = 1'b0;

      // Saturation: preload the counter near the top, then three bubbles.
      force dut.stall_count_q = 16'hFFFD;
      #1;
      release dut.stall_count_q;
      for (int k = 0; k < 3; k++) begin
         drive_lw();
         tick();
         drive_add();
         #1;
         check("sat_stall", 64'(stall), 64'd1);
         tick();
         check("sat_count", 64'(stall_count), (k == 0) ? 64'hFFFE : 64'hFFFF);
      end

      // Asynchronous reset in the middle of a stall.
      drive_lw();
      tick();
      drive_add();
      #1;
      check("pre_rst_stall", 64'(stall), 64'd1);
      reset = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_count", 64'(stall_count), 64'd0);
      check("arst_ex", 64'(execute_bus), 64'd0);
      check("arst_rt", 64'(out_rt), 64'd0);
      check("arst_pc", 64'(out_pc_branch), 64'd0);
      check("arst_stall", 64'(stall), 64'd0);
      reset = 1'b1;

      // First edge after reset loads; the register file was cleared.
      in_instruccion = 32'h00A0_0000;
      tick();
      check("post_rst_valid", 64'(out_valid), 64'd1);
      check("post_rst_ex", 64'(execute_bus), 64'h1C2);
      check("post_rst_r5", 64'(out_reg1), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter LEN, default 32, datapath width in bits; legal range 32..64.
REQ-002 Parameter NREG, default 32, number of architectural registers; legal range 8..32.
REQ-003 Parameter EX_W, default 9, execute control bus width.
REQ-004 Parameter MEM_W, default 3, memory control bus width.
REQ-005 Parameter WB_W, default 2, writeback control bus width.
REQ-006 Parameter MEMREAD_BIT, default 1, index in memory_bus that flags a load.
REQ-007 Ports SHALL be as follows:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  IF/ID holds a real instruction.
- in_pc_branch  in  LEN  PC+4 of the instruction.
- in_instruccion  in  32  instruction word.
- in_execute_bus  in  EX_W  from the control unit.
- in_memory_bus  in  MEM_W  from the control unit.
- in_writeBack_bus  in  WB_W  from the control unit.
- in_zero_ext  in  1  zero-extend the immediate instead of sign-extending it.
- RegWrite  in  1  writeback enable.
- write_register  in  5  writeback index.
- write_data  in  LEN  writeback data.
- flush  in  1  kill the instruction in decode.
- hold  in  1  downstream freeze.
- stall  out  1  freeze PC and IF/ID.
- out_valid  out  1  ID/EX holds a real instruction.
- out_pc_branch, out_reg1, out_reg2, out_sign_extend  out  LEN each.
- out_pc_jump  out  LEN  combinational jump target.
- out_rs, out_rt, out_rd, out_shamt  out  5 each.
- execute_bus  out  EX_W; memory_bus  out  MEM_W; writeBack_bus  out  WB_W.
- stall_count  out  16  count of hazard stall cycles.

Function
REQ-008 Register file SHALL have NREG x LEN entries; register 0 SHALL read as 0; writes to index 0 or to an index >= NREG SHALL be ignored; reads of an index >= NREG SHALL return 0.
REQ-009 A write SHALL occur on the rising clk edge when RegWrite=1; a read in the same cycle of the register being written (nonzero index) SHALL return write_data (write-first bypass).
REQ-010 out_pc_jump SHALL equal {in_pc_branch[LEN-1:28], in_instruccion[25:0], 2'b00}, combinationally.
REQ-011 Immediate: in_zero_ext=0 SHALL sign-extend in_instruccion[15:0] to LEN; in_zero_ext=1 SHALL zero-extend it.
REQ-012 Hazard: stall SHALL be 1 (combinational) when in_valid=1, out_valid=1, memory_bus[MEMREAD_BIT]=1, out_rt!=0, and out_rt equals in_instruccion[25:21] or in_instruccion[20:16]; otherwise 0.
REQ-013 Each edge SHALL apply exactly one action, with priority flush > hold > hazard > load.
REQ-014 Flush: out_valid and all three control buses SHALL be set to 0; the datapath registers need not change.
REQ-015 Hold: every ID/EX register SHALL retain its value, and stall_count SHALL not change.
REQ-016 Hazard (stall=1, no flush or hold): a bubble SHALL be inserted (out_valid=0, control buses 0); the datapath registers need not change; the instruction stays in IF/ID.
REQ-017 Load: all ID/EX registers SHALL capture the decoded values; out_valid=in_valid; when in_valid=0 the control buses SHALL load 0.
REQ-018 Decode-to-output latency SHALL be one clock cycle.
REQ-019 A load-use pair SHALL cost exactly one bubble: the edge after a bubble clears out_valid, so stall falls.
REQ-020 stall_count SHALL increment on each edge where a hazard bubble is inserted and SHALL saturate at 16'hFFFF without wrapping.
REQ-021 When flush and stall are both 1, the flush SHALL win, no bubble SHALL be counted, and the stall output SHALL still reflect REQ-012.

Reset
REQ-022 reset=0 SHALL asynchronously clear all registered outputs, all register-file entries and stall_count to 0.
REQ-023 Reset asserted mid-operation SHALL discard any in-flight instruction; the first edge after reset release SHALL behave as a load.

Verification
REQ-024 Write r5=0x1234 and read rs=r5 in the same cycle -> out_reg1=0x00001234 one cycle later.
REQ-025 Write r0=0xFFFF_FFFF, then read r0 -> out_reg1=0.
REQ-026 lw r3 issued, next instruction add with rs=r3 -> stall=1 for one cycle; one bubble (out_valid=0, execute_bus=0); add appears the following cycle; stall_count=1.
REQ-027 Immediate 0x8000 -> out_sign_extend=0xFFFF8000 with in_zero_ext=0 and 0x00008000 with in_zero_ext=1.
REQ-028 flush=1 and hold=1 in the same cycle -> out_valid=0 next cycle; then hold alone for 3 cycles -> all outputs frozen.
REQ-029 Preload stall_count to 0xFFFE by forcing 3 load-use stalls -> counter reads 0xFFFF and holds; assert reset=0 mid-stall -> all outputs 0 immediately, without waiting for a clk edge.
